apb_rr_arbiter: RTL and testbench
=================================

# apb_rr_arbiter

Two-port round-robin arbiter and sequencer for a single APB master bus. It sits between the uart2apb bridge (port 0) and a second on-chip requester (port 1), such as a debug or DMA engine, and drives the shared APB signals. Each accepted request is run as exactly one APB transfer, with a watchdog that aborts a transfer whose slave never raises `apb_pready`. Completion is reported to the owning port as a one-cycle acknowledge carrying read data and an error flag.

## Interface
Parameters:
- `ADDR_W`, 16, APB address width.
- `DATA_W`, 32, APB data width.
- `TIMEOUT`, 255, maximum ACCESS cycles without `apb_pready` before abort; 0 disables the watchdog. Counter width is clog2(TIMEOUT+1), minimum 1.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: the single clock.
  - `rst` in 1: synchronous, active-high reset.
- Port x = 0 and port x = 1:
  - `mx_req` in 1: request; held high until `mx_ack`.
  - `mx_write` in 1: 1 = write, 0 = read; stable while `mx_req` is high.
  - `mx_addr` in ADDR_W: transfer address; stable while `mx_req` is high.
  - `mx_wdata` in DATA_W: write data; stable while `mx_req` is high.
  - `mx_ack` out 1: one-cycle completion pulse.
  - `mx_rdata` out DATA_W: read data; valid with `mx_ack`.
  - `mx_err` out 1: timeout flag; valid with `mx_ack`.
- APB:
  - `apb_psel` out 1, `apb_penable` out 1, `apb_pwrite` out 1.
  - `apb_paddr` out ADDR_W, `apb_pwdata` out DATA_W.
  - `apb_pready` in 1, `apb_prdata` in DATA_W.

## Operation
- States: IDLE → SETUP → ACCESS → DONE → IDLE.
- IDLE:
  - Samples `m0_req` and `m1_req`.
  - Single requester: that port wins.
  - Both requesting: the port other than `last_gnt` wins.
  - The winner is latched in `gnt`, and its write/addr/wdata are registered onto the APB outputs.
  - No request: stay in IDLE.
- SETUP: `apb_psel`=1, `apb_penable`=0. Always exactly one cycle, then ACCESS.
- ACCESS:
  - `apb_psel`=1, `apb_penable`=1; the watchdog counter increments each cycle.
  - `apb_pready`=1: capture `apb_prdata` (reads only; writes return 0), clear err, go to DONE.
  - Else if TIMEOUT≠0 and the counter equals TIMEOUT-1: rdata=0, err=1, go to DONE.
- DONE:
  - `apb_psel` and `apb_penable` are both 0.
  - `mgnt_ack`=1 for this one cycle, with rdata and err.
  - `last_gnt` ← `gnt`.
  - Requests are not sampled in this state. The next state is IDLE unconditionally.
- Master rule: drop `mx_req` on the edge where `mx_ack` is seen. A request still high in the following IDLE is treated as a new transfer.
- The non-granted port's req is ignored, and its outputs are untouched, until the next IDLE.
- `mx_rdata` and `mx_err` hold their last value between acks. Only the granted port's copies update.
- APB address, write and wdata outputs hold stable from SETUP through ACCESS. They may hold stale values in IDLE and DONE.

## Timing
- All outputs are registered. Values after `rst`:
  - state IDLE, `last_gnt`=1, so port 0 wins the first tie.
  - all ack, err, psel and penable = 0.
  - paddr, pwdata, pwrite and all rdata = 0.
- Zero-wait transfer, with req high in IDLE at cycle N:
  - SETUP at N+1.
  - ACCESS at N+2 (pready sampled).
  - DONE/ack at N+3.
  - IDLE at N+4.
- Each cycle of `apb_pready`=0 adds one ACCESS cycle.
- Timeout with TIMEOUT=T: exactly T ACCESS cycles, then DONE with err=1.
- pready in the last allowed ACCESS cycle: this counts as a success, because pready has priority over timeout.
- `apb_pready` outside ACCESS is ignored.
- Back-to-back with both ports requesting continuously: grants alternate 0,1,0,1…, with one transfer every 4 cycles at zero wait.
- `rst` asserted in any state:
  - the next cycle is IDLE with all reset values.
  - An in-flight transfer is abandoned with no ack.
  - `psel` and `penable` drop the cycle after `rst` is sampled.

## Structure
- Package `apb_arb_pkg`:
  - state encoding constants (IDLE, SETUP, ACCESS, DONE).
  - default ADDR_W and DATA_W.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick.
  - Inputs: `req[1:0]`, `last_gnt`.
  - Outputs: `gnt`, `gnt_valid`.
- The top level holds the FSM, the watchdog counter and the output registers.

## Test plan
- Zero-wait read, pready=1 and prdata=0x5567A9CF: port 0 reads 0x1771. Expect:
  - `apb_paddr`=0x1771, `apb_pwrite`=0.
  - `m0_ack` at N+3, with `m0_rdata`=0x5567A9CF and `m0_err`=0.
- Wait-state write: port 1 writes 0x77A4C5A5 to 0x0550, pready low for 3 ACCESS cycles. Expect:
  - 4 ACCESS cycles, with `apb_pwdata` stable throughout.
  - `m1_ack` at N+6 and `m1_rdata`=0.
- Arbitration: both ports request from reset, and each re-requests right after its ack. Expect:
  - grant order 0,1,0,1.
  - `m1` sees no ack while `m0` is granted.
- Timeout: TIMEOUT=8 and pready held low. Expect:
  - exactly 8 ACCESS cycles.
  - ack with err=1 and rdata=0.
  - the next transfer runs normally.
- Boundary case: pready=1 on the 8th ACCESS cycle with TIMEOUT=8. Expect err=0 and the captured prdata.
- Reset mid-ACCESS. Expect:
  - `psel` and `penable` are 0 the next cycle, with no ack.
  - the following request from port 0 wins even if port 1 also requests.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-port APB round-robin arbiter.
package apb_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Watchdog counter width: clog2(TIMEOUT+1), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not
// win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt       = (req == 2'b11) ? ~last_gnt : req[1];
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-port round-robin arbiter that runs one APB transfer per accepted request,
// with a watchdog that aborts ACCESS phases whose slave never asserts pready.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // req/ack handshake: a master raises mx_req with write/addr/wdata stable
    // and holds it until the one-cycle mx_ack; a req still high in the IDLE
    // cycle after the ack is taken as a fresh transfer.
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic              apb_pready,
    input  logic [DATA_W-1:0] apb_prdata,
    output state_t            o_dbg_state
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_gnt;
    logic              r_last_gnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt;
    logic              w_gnt_valid;
    logic              w_timeout;
    logic              w_finish;
    logic              w_fin_err;
    logic [DATA_W-1:0] w_fin_rdata;

    rr_arb2 u_pick (
        .req       ({m1_req, m0_req}),
        .last_gnt  (r_last_gnt),
        .gnt       (w_gnt),
        .gnt_valid (w_gnt_valid)
    );

    // pready wins over the watchdog when both land on the same cycle.
    always_comb begin
        w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);
        w_finish    = (r_state == ST_ACCESS) && (apb_pready || w_timeout);
        w_fin_err   = !apb_pready;
        w_fin_rdata = (apb_pready && !r_pwrite) ? apb_prdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_ack      <= 2'b00;
            r_err      <= 2'b00;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt    <= w_gnt;
                        r_pwrite <= w_gnt ? m1_write : m0_write;
                        r_paddr  <= w_gnt ? m1_addr  : m0_addr;
                        r_pwdata <= w_gnt ? m1_wdata : m0_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_finish) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_ack[r_gnt] <= 1'b1;
                        r_err[r_gnt] <= w_fin_err;
                        if (r_gnt) r_rdata1 <= w_fin_rdata;
                        else       r_rdata0 <= w_fin_rdata;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last_gnt <= r_gnt;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack      = r_ack[0];
    assign m1_ack      = r_ack[1];
    assign m0_err      = r_err[0];
    assign m1_err      = r_err[1];
    assign m0_rdata    = r_rdata0;
    assign m1_rdata    = r_rdata1;
    assign apb_psel    = r_psel;
    assign apb_penable = r_penable;
    assign apb_pwrite  = r_pwrite;
    assign apb_paddr   = r_paddr;
    assign apb_pwdata  = r_pwdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: vector table of single transfers, arbitration and
// reset sequences, with an APB slave model and an expected-completion queue.
module tb_apb_rr_arbiter;
    import apb_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_write, m1_req, m1_write;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          apb_psel, apb_penable, apb_pwrite, apb_pready;
    logic [AW-1:0] apb_paddr;
    logic [DW-1:0] apb_pwdata, apb_prdata;
    state_t        dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata),
        .o_dbg_state(dbg_state)
    );

    typedef struct packed {
        logic          port;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        logic [7:0]    acc;
    } exp_t;

    typedef struct {
        logic          port;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        int            wt;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_acc;
    } vec_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            acc = 0;
    int            cur_wait = 0;
    logic [DW-1:0] mdl_rdata[2];
    logic          mdl_err[2];
    exp_t          mon_e;
    logic          mon_p;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor, scoreboard and APB slave model, all on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            acc = 0;
            apb_pready = 1'b0;
        end else begin
            if (apb_psel) begin
                if (exp_q.size() == 0) fail_now("psel_without_pending");
                else begin
                    check("paddr", DW'(apb_paddr), DW'(exp_q[0].addr));
                    check("pwrite", DW'(apb_pwrite), DW'(exp_q[0].write));
                    if (exp_q[0].write) check("pwdata", apb_pwdata, exp_q[0].wdata);
                end
            end
            if (m0_ack || m1_ack) begin
                check("ack_onehot", DW'(m0_ack && m1_ack), 32'd0);
                check("ack_psel_pen", DW'({apb_psel, apb_penable}), 32'd0);
                if (exp_q.size() == 0) fail_now("ack_unexpected");
                else begin
                    mon_e = exp_q.pop_front();
                    mon_p = m1_ack;
                    check("ack_port", DW'(mon_p), DW'(mon_e.port));
                    check("ack_rdata", mon_p ? m1_rdata : m0_rdata, mon_e.rdata);
                    check("ack_err", DW'(mon_p ? m1_err : m0_err), DW'(mon_e.err));
                    check("access_cycles", DW'(acc), DW'(mon_e.acc));
                    mdl_rdata[mon_p] = mon_e.rdata;
                    mdl_err[mon_p]   = mon_e.err;
                    check("other_rdata_hold", mon_p ? m0_rdata : m1_rdata, mdl_rdata[!mon_p]);
                    check("other_err_hold", DW'(mon_p ? m0_err : m1_err), DW'(mdl_err[!mon_p]));
                end
                acc = 0;
            end
            if (apb_psel && apb_penable) begin
                apb_pready = (acc == cur_wait);
                acc++;
            end else begin
                apb_pready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic reset_model();
        mdl_rdata[0] = '0; mdl_rdata[1] = '0;
        mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
    endtask

    task automatic do_xfer(input vec_t v);
        exp_t e;
        int   lat;
        bit   got;
        e = '{port: v.port, write: v.write, addr: v.addr, wdata: v.wdata,
              rdata: v.exp_rdata, err: v.exp_err, acc: 8'(v.exp_acc)};
        exp_q.push_back(e);
        cur_wait   = v.wt;
        apb_prdata = v.prdata;
        @(posedge clk); #1;
        if (v.port) begin
            m1_write = v.write; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
        end else begin
            m0_write = v.write; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
        end
        lat = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if ((v.port && m1_ack) || (!v.port && m0_ack)) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("ack_wait_expired");
        else check("ack_latency", DW'(lat), DW'(2 + v.exp_acc));
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
    endtask

    // Both ports request continuously; grants must alternate starting at port 0.
    task automatic run_both(input int n);
        exp_t e;
        int   rem0, rem1, last_ack;
        bit   done;
        cur_wait   = 0;
        apb_prdata = 32'h0BAD_BEEF;
        for (int k = 0; k < n; k++) begin
            e = '{port: 1'b0, write: 1'b0, addr: AW'(16'h0100 + k * 4), wdata: '0,
                  rdata: 32'h0BAD_BEEF, err: 1'b0, acc: 8'd1};
            exp_q.push_back(e);
            e = '{port: 1'b1, write: 1'b1, addr: AW'(16'h0200 + k * 4), wdata: 32'h1111_0000 + DW'(k),
                  rdata: '0, err: 1'b0, acc: 8'd1};
            exp_q.push_back(e);
        end
        rem0 = n; rem1 = n; last_ack = -1; done = 0;
        @(posedge clk); #1;
        m0_write = 1'b0; m0_addr = 16'h0100; m0_wdata = '0; m0_req = 1'b1;
        m1_write = 1'b1; m1_addr = 16'h0200; m1_wdata = 32'h1111_0000; m1_req = 1'b1;
        for (int i = 0; i < 20 * n; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) begin
                if (last_ack >= 0) check("ack_spacing", DW'(cyc - last_ack), 32'd4);
                last_ack = cyc;
            end
            if (m0_ack) begin
                rem0--; m0_req = 1'b0;
            end else if (!m0_req && rem0 > 0) begin
                m0_addr = AW'(16'h0100 + (n - rem0) * 4); m0_req = 1'b1;
            end
            if (m1_ack) begin
                rem1--; m1_req = 1'b0;
            end else if (!m1_req && rem1 > 0) begin
                m1_addr = AW'(16'h0200 + (n - rem1) * 4);
                m1_wdata = 32'h1111_0000 + DW'(n - rem1); m1_req = 1'b1;
            end
            if (rem0 == 0 && rem1 == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("arbitration_wait_expired");
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h1771, 32'h0, 32'h5567_A9CF, 0, 32'h5567_A9CF, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b1, 16'h0550, 32'h77A4_C5A5, 32'hDEAD_0001, 3, 32'h0, 1'b0, 4};
        vecs[2] = '{1'b0, 1'b0, 16'h00F0, 32'h0, 32'h1234_5678, 20, 32'h0, 1'b1, 8};
        vecs[3] = '{1'b0, 1'b0, 16'h00F4, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 32'h0, 32'hA5A5_A5A5, 7, 32'hA5A5_A5A5, 1'b0, 8};
        vecs[5] = '{1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h5555_0000, 8, 32'h0, 1'b1, 8};
        vecs[6] = '{1'b0, 1'b1, 16'h8001, 32'h0F0F_0F0F, 32'h3C3C_3C3C, 1, 32'h0, 1'b0, 2};
        vecs[7] = '{1'b1, 1'b0, 16'h2222, 32'h0, 32'h0000_0001, 2, 32'h0000_0001, 1'b0, 3};
        for (int i = 8; i < 14; i++) begin
            vecs[i].port   = 1'($urandom_range(0, 1));
            vecs[i].write  = 1'($urandom_range(0, 1));
            vecs[i].addr   = AW'($urandom);
            vecs[i].wdata  = $urandom;
            vecs[i].prdata = $urandom;
            vecs[i].wt     = int'($urandom_range(0, 10));
            if (vecs[i].wt < TO) begin
                vecs[i].exp_acc   = vecs[i].wt + 1;
                vecs[i].exp_err   = 1'b0;
                vecs[i].exp_rdata = vecs[i].write ? '0 : vecs[i].prdata;
            end else begin
                vecs[i].exp_acc   = TO;
                vecs[i].exp_err   = 1'b1;
                vecs[i].exp_rdata = '0;
            end
        end

        rst = 1'b1;
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
        apb_prdata = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_state", DW'(dbg_state), DW'(ST_IDLE));
        check("rst_m0_ack", DW'(m0_ack), 32'd0);
        check("rst_m1_ack", DW'(m1_ack), 32'd0);
        check("rst_m0_err", DW'(m0_err), 32'd0);
        check("rst_m1_err", DW'(m1_err), 32'd0);
        check("rst_psel", DW'(apb_psel), 32'd0);
        check("rst_penable", DW'(apb_penable), 32'd0);
        check("rst_pwrite", DW'(apb_pwrite), 32'd0);
        check("rst_paddr", DW'(apb_paddr), 32'd0);
        check("rst_pwdata", apb_pwdata, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);

        run_both(2);

        for (int i = 0; i < 14; i++) do_xfer(vecs[i]);

        // Reset in the middle of a stalled ACCESS phase.
        begin
            exp_t e;
            bit   hit;
            e = '{port: 1'b0, write: 1'b0, addr: 16'h3333, wdata: '0, rdata: '0, err: 1'b0, acc: 8'd0};
            exp_q.push_back(e);
            cur_wait = 50;
            @(posedge clk); #1;
            m0_write = 1'b0; m0_addr = 16'h3333; m0_req = 1'b1;
            hit = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (apb_psel && apb_penable) begin
                    hit = 1;
                    break;
                end
            end
            if (!hit) fail_now("access_wait_expired");
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            m0_req = 1'b0;
            exp_q.delete();
            reset_model();
            check("midrst_psel", DW'(apb_psel), 32'd0);
            check("midrst_penable", DW'(apb_penable), 32'd0);
            check("midrst_state", DW'(dbg_state), DW'(ST_IDLE));
            check("midrst_m0_rdata", m0_rdata, 32'd0);
            check("midrst_paddr", DW'(apb_paddr), 32'd0);
            for (int i = 0; i < 3; i++) begin
                check("midrst_no_ack", DW'({m0_ack, m1_ack}), 32'd0);
                @(posedge clk); #1;
            end
        end

        run_both(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
